vx_csr_arb_unit: RTL
====================

VX_CSR_ARB_UNIT -- requirements
Module: vx_csr_arb_unit

Interface
REQ-001 SHALL have parameter NUM_REQS, default 2: number of independent CSR issue channels, range 1..8.
REQ-002 SHALL have parameter CSR_DATAW, default 32: CSR data width, 32 or 64.
REQ-003 SHALL have parameter RSP_DEPTH, default 2: response queue entries, at least 1.
REQ-004 SHALL have parameter TAG_WIDTH, default 8: opaque request tag width, passed through.
REQ-005 SHALL have ports: clk  in  1  the one clock; reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: req_valid / req_ready  in / out  NUM_REQS  per-channel request handshake.
REQ-007 SHALL have port: req_data  in  NUM_REQS x csr_req_t  fields wid, op (RW/RS/RC), addr[11:0], use_imm, imm[4:0], rs1[CSR_DATAW], tag.
REQ-008 SHALL have ports: alm_empty_wid  out  NW_WIDTH  warp being drained; alm_empty  in  1  that warp has no pending instructions.
REQ-009 SHALL have ports: unlock_valid  out  1  one-cycle warp-unlock pulse; unlock_wid  out  NW_WIDTH  warp to unlock.
REQ-010 SHALL have ports: csr_rd_en  out  1; csr_rd_addr  out  12; csr_rd_data  in  CSR_DATAW, valid the cycle after csr_rd_en.
REQ-011 SHALL have ports: csr_wr_en  out  1; csr_wr_addr  out  12; csr_wr_data  out  CSR_DATAW.
REQ-012 SHALL have ports: rsp_valid / rsp_ready  out / in  1; rsp_data  out  CSR_DATAW (old CSR value); rsp_tag  out  TAG_WIDTH; rsp_src  out  UP(CLOG2(NUM_REQS)).
REQ-013 SHALL have port: drain_stall_cycles  out  32  perf counter.

Function
REQ-014 SHALL use FSM states IDLE, DRAIN, READ, MODIFY, with exactly one request in flight.
REQ-015 In IDLE with the response queue not full, SHALL grant one valid channel round-robin, starting at rr_ptr; it SHALL assert req_ready only for that channel, latch its req_data, and go to DRAIN.
REQ-016 After a grant to channel g, rr_ptr SHALL become (g+1) mod NUM_REQS; rr_ptr SHALL NOT change without a grant.
REQ-017 In IDLE with the queue full, all req_ready SHALL be 0.
REQ-018 In DRAIN, alm_empty_wid SHALL equal the latched wid; the block SHALL go to READ on alm_empty=1 and otherwise stay, incrementing drain_stall_cycles, which saturates at 0xFFFFFFFF.
REQ-019 In READ, the block SHALL pulse csr_rd_en for one cycle with csr_rd_addr = latched addr, then go to MODIFY.
REQ-020 Source operand: src = use_imm ? zero-extended imm : rs1.
REQ-021 Write data: RW gives src; RS gives rd_data|src; RC gives rd_data&~src.
REQ-022 csr_wr_en SHALL pulse in MODIFY only if op==RW or src!=0.
REQ-023 In MODIFY, the block SHALL also push {rd_data, tag, src channel} into the queue, pulse unlock_valid with unlock_wid = latched wid, and return to IDLE.
REQ-024 Latency: grant at cycle T with alm_empty=1 SHALL give csr_rd_en at T+2, csr_wr_en and unlock at T+3, and rsp_valid at T+4. Peak throughput SHALL be one request per 4 cycles.
REQ-025 Each DRAIN stall cycle SHALL add exactly one cycle to the latency.
REQ-026 The response queue SHALL be FIFO-ordered; an entry is popped when rsp_valid && rsp_ready. A push and a pop in the same cycle while full SHALL NOT occur, because a grant requires not-full and nothing else pushes.
REQ-027 rsp_valid SHALL NOT depend combinationally on req_valid.

Reset
REQ-028 When reset=0 (asynchronous), the block SHALL enter IDLE with rr_ptr=0, the queue empty and drain_stall_cycles=0, and drive all outputs to 0.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight request with no csr_wr_en, no unlock and no response.
REQ-030 After reset deassertion, the first grant SHALL go to the lowest valid index.

Structure
REQ-031 csr_req_t and the CSR op encodings (RW=0, RS=1, RC=2) SHALL live in VX_gpu_pkg.
REQ-032 The response queue SHALL be one VX_fifo_queue instance of DATAW = CSR_DATAW+TAG_WIDTH+UP(CLOG2(NUM_REQS)) and DEPTH = RSP_DEPTH.
REQ-033 The arbiter and FSM SHALL be implemented inline.

Verification
REQ-034 Single request on ch0, CSRRS addr 0x300, rs1=0x4, rd_data=0x10, alm_empty=1 -> csr_wr_data 0x14 at T+3; rsp_data 0x10 at T+4; unlock pulse at T+3.
REQ-035 ch0 and ch1 held valid continuously -> grants alternate 0,1,0,1; rsp_src order matches.
REQ-036 CSRRC with use_imm=1, imm=0 -> no csr_wr_en; response still returned; unlock still pulsed.
REQ-037 alm_empty held 0 for 5 cycles in DRAIN -> drain_stall_cycles +5; csr_rd_en at T+7.
REQ-038 RSP_DEPTH=2, rsp_ready=0, three requests -> two responses queued; third req_ready=0 until one pop.
REQ-039 reset pulsed low during READ -> no csr_wr_en, no unlock, rsp_valid=0, rr_ptr=0 afterwards.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// Shared GPU types: CSR request record, CSR op encodings, arbiter FSM states.
// The request struct is sized for the widest supported configuration
// (64-bit CSR data, 16-bit tag); users take the low bits they need.
package VX_gpu_pkg;

  localparam int NUM_WARPS     = 4;
  localparam int NW_WIDTH      = 2;
  localparam int CSR_DATAW_MAX = 64;
  localparam int TAG_WIDTH_MAX = 16;

  typedef enum logic [1:0] {
    CSR_RW = 2'd0,
    CSR_RS = 2'd1,
    CSR_RC = 2'd2
  } csr_op_e;

  typedef struct packed {
    logic [NW_WIDTH-1:0]      wid;
    csr_op_e                  op;
    logic [11:0]              addr;
    logic                     use_imm;
    logic [4:0]               imm;
    logic [CSR_DATAW_MAX-1:0] rs1;
    logic [TAG_WIDTH_MAX-1:0] tag;
  } csr_req_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_READ   = 2'd2,
    ST_MODIFY = 2'd3
  } arb_state_e;

  // Width of an index into n items, never less than one bit.
  function automatic int up_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/VX_fifo_queue.sv
// Small register-based FIFO with occupancy counter; head is shown while not empty.
module VX_fifo_queue #(
  parameter int DATAW = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign empty    = (cnt_r == CNT_W'(0));
  assign full     = (cnt_r == CNT_W'(DEPTH));
  assign data_out = mem_r[rd_ptr_r];

  // Storage array: written at the tail on an accepted push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Head/tail pointers and occupancy tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/vx_csr_arb_unit.sv
// CSR arbiter: round-robin grant over issue channels, drains the owning warp,
// performs a read-modify-write on the CSR file and queues the old value back.
module vx_csr_arb_unit
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS  = 2,
  parameter int CSR_DATAW = 32,
  parameter int RSP_DEPTH = 2,
  parameter int TAG_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  output logic [NUM_REQS-1:0]           req_ready,
  input  csr_req_t [NUM_REQS-1:0]       req_data,
  output logic [NW_WIDTH-1:0]           alm_empty_wid,
  input  logic                          alm_empty,
  output logic                          unlock_valid,
  output logic [NW_WIDTH-1:0]           unlock_wid,
  output logic                          csr_rd_en,
  output logic [11:0]                   csr_rd_addr,
  input  logic [CSR_DATAW-1:0]          csr_rd_data,
  output logic                          csr_wr_en,
  output logic [11:0]                   csr_wr_addr,
  output logic [CSR_DATAW-1:0]          csr_wr_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [CSR_DATAW-1:0]          rsp_data,
  output logic [TAG_WIDTH-1:0]          rsp_tag,
  output logic [up_clog2(NUM_REQS)-1:0] rsp_src,
  output logic [31:0]                   drain_stall_cycles
);

  localparam int SRC_W = up_clog2(NUM_REQS);
  localparam int QW    = CSR_DATAW + TAG_WIDTH + SRC_W;

  arb_state_e           state_r;
  arb_state_e           state_nxt;
  csr_req_t             req_r;
  logic [SRC_W-1:0]     chan_r;
  logic [SRC_W-1:0]     rr_ptr_r;
  logic [SRC_W-1:0]     grant_idx;
  logic                 grant_found;
  logic                 grant_fire;
  logic [31:0]          stall_r;
  logic                 q_full;
  logic                 q_empty;
  logic                 q_push;
  logic                 q_pop;
  logic [QW-1:0]        q_din;
  logic [QW-1:0]        q_dout;
  logic [CSR_DATAW-1:0] src_val;
  logic [CSR_DATAW-1:0] wr_val;
  logic                 wr_allowed;
  logic                 unused_req_bits;

  // Only the low rs1/tag bits matter for narrower configurations.
  assign unused_req_bits = ^{req_r.rs1, req_r.tag};

  // Round-robin search: first valid channel at or after rr_ptr.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= NUM_REQS) begin
        idx = idx - NUM_REQS;
      end else begin
        idx = idx;
      end
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(idx);
      end else begin
        grant_found = grant_found;
      end
    end
  end

  // A grant needs IDLE, queue space and reset released.
  always_comb begin
    grant_fire = reset && (state_r == ST_IDLE) && !q_full && grant_found;
    req_ready  = '0;
    if (grant_fire) begin
      req_ready[grant_idx] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Source operand and read-modify-write data for the latched request.
  always_comb begin
    if (req_r.use_imm) begin
      src_val = CSR_DATAW'(req_r.imm);
    end else begin
      src_val = req_r.rs1[CSR_DATAW-1:0];
    end
    case (req_r.op)
      CSR_RW: begin
        wr_val     = src_val;
        wr_allowed = 1'b1;
      end
      CSR_RS: begin
        wr_val     = csr_rd_data | src_val;
        wr_allowed = (src_val != '0);
      end
      CSR_RC: begin
        wr_val     = csr_rd_data & ~src_val;
        wr_allowed = (src_val != '0);
      end
      default: begin
        // Undefined op: leave the CSR untouched.
        wr_val     = csr_rd_data;
        wr_allowed = 1'b0;
      end
    endcase
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_fire) begin
          state_nxt = ST_DRAIN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (alm_empty) begin
          state_nxt = ST_READ;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_READ:   state_nxt = ST_MODIFY;
      ST_MODIFY: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM-decoded outputs toward the warp scheduler and CSR file.
  always_comb begin
    alm_empty_wid = '0;
    unlock_valid  = 1'b0;
    unlock_wid    = '0;
    csr_rd_en     = 1'b0;
    csr_rd_addr   = 12'd0;
    csr_wr_en     = 1'b0;
    csr_wr_addr   = 12'd0;
    csr_wr_data   = '0;
    case (state_r)
      ST_DRAIN: begin
        alm_empty_wid = req_r.wid;
      end
      ST_READ: begin
        csr_rd_en   = 1'b1;
        csr_rd_addr = req_r.addr;
      end
      ST_MODIFY: begin
        unlock_valid = 1'b1;
        unlock_wid   = req_r.wid;
        if (wr_allowed) begin
          csr_wr_en   = 1'b1;
          csr_wr_addr = req_r.addr;
          csr_wr_data = wr_val;
        end else begin
          csr_wr_en   = 1'b0;
        end
      end
      default: begin
        alm_empty_wid = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Capture the granted request and its source channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_r  <= '0;
      chan_r <= '0;
    end else if (grant_fire) begin
      req_r  <= req_data[grant_idx];
      chan_r <= grant_idx;
    end
  end

  // Round-robin pointer moves past the granted channel only on a grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_r <= '0;
    end else if (grant_fire) begin
      if (grant_idx == SRC_W'(NUM_REQS - 1)) begin
        rr_ptr_r <= '0;
      end else begin
        rr_ptr_r <= grant_idx + SRC_W'(1);
      end
    end
  end

  // Saturating count of cycles spent waiting for the warp to drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_r <= 32'd0;
    end else if ((state_r == ST_DRAIN) && !alm_empty && (stall_r != 32'hFFFF_FFFF)) begin
      stall_r <= stall_r + 32'd1;
    end
  end

  assign drain_stall_cycles = stall_r;

  assign q_push    = (state_r == ST_MODIFY);
  assign q_din     = {csr_rd_data, req_r.tag[TAG_WIDTH-1:0], chan_r};
  assign rsp_valid = !q_empty;
  assign q_pop     = rsp_valid && rsp_ready;
  assign rsp_data  = q_dout[QW-1 -: CSR_DATAW];
  assign rsp_tag   = q_dout[SRC_W +: TAG_WIDTH];
  assign rsp_src   = q_dout[SRC_W-1:0];

  VX_fifo_queue #(
    .DATAW (QW),
    .DEPTH (RSP_DEPTH)
  ) rsp_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (q_push),
    .pop      (q_pop),
    .data_in  (q_din),
    .data_out (q_dout),
    .empty    (q_empty),
    .full     (q_full)
  );

endmodule
